frame_buffer_arbiter: RTL and testbench
=======================================

# frame_buffer_arbiter

Single-port frame-buffer arbiter between the camera write stream and the VGA read stream, both in the `vgaclk` domain. VGA reads win every cycle they are requested. Camera writes are queued in a small FIFO and drained into the RAM during blanking and other idle read cycles. It sits between the camera controller, the VGA controller and the single-port frame RAM, and replaces the button-driven address/wren mux.

## Interface
- `AW`, 15, RAM address width
- `DW`, 16, pixel/data width
- `DEPTH`, 8, write FIFO depth, power of two, ≥2
- `vgaclk`  in  1  pixel clock, all logic on rising edge
- `reset_b`  in  1  asynchronous, active-low reset
- `capture_en`  in  1  1 = accept camera writes; 0 = new writes ignored, queued writes still drain
- `wr_req`  in  1  camera write request
- `wr_addr`  in  AW  camera write address
- `wr_data`  in  DW  camera pixel
- `wr_ready`  out  1  FIFO not full
- `rd_req`  in  1  VGA read request (active display)
- `rd_addr`  in  AW  VGA read address
- `rd_valid`  out  1  `rd_data` valid this cycle
- `rd_data`  out  DW  read pixel; 0 when `rd_valid`=0
- `ram_addr`  out  AW  to RAM address
- `ram_data`  out  DW  to RAM write data
- `ram_wren`  out  1  to RAM write enable
- `ram_q`  in  DW  RAM read data, one cycle after address
- `level`  out  $clog2(DEPTH)+1  FIFO occupancy
- `drop_cnt`  out  8  dropped writes, saturates at 255
- `drop_clr`  in  1  synchronous clear of `drop_cnt`

## Operation
- Push: `wr_req & capture_en & ~full` writes {`wr_addr`,`wr_data`} to the FIFO tail.
- Drop: `wr_req & capture_en & full` discards the write and increments `drop_cnt`. No push on a full FIFO, even if a pop occurs in the same cycle.
- `wr_req` with `capture_en`=0 is ignored and not counted.
- Grant, decided combinationally each cycle, priority order:
  - RD if `rd_req`: `ram_addr`=`rd_addr`, `ram_wren`=0.
  - else WR if FIFO not empty: pop head, `ram_addr`/`ram_data`=head, `ram_wren`=1.
  - else NONE: `ram_addr`=0, `ram_wren`=0.
- `ram_data` always carries the FIFO head, or 0 when the FIFO is empty.
- Last-grant register `gnt_q` has states G_NONE, G_RD, G_WR and loads the current grant every cycle.
- `rd_valid` = (`gnt_q`==G_RD); `rd_data` = `rd_valid` ? `ram_q` : 0.
- Push and pop in the same cycle leave `level` unchanged.
- Pointers are $clog2(DEPTH) bits and wrap naturally. full = (`level`==DEPTH), empty = (`level`==0).
- No read-after-write forwarding. A read to an address still queued returns old RAM content (one frame stale).
- `drop_clr` together with a drop in the same cycle: the result is 0.
- Reset mid-operation: FIFO contents are discarded and any in-flight read result is lost (`rd_valid`=0 next cycle).

## Timing
- Reset values: `gnt_q`=G_NONE, pointers=0, `level`=0, `drop_cnt`=0, `rd_valid`=0, `rd_data`=0, `ram_wren`=0, `ram_addr`=0, `ram_data`=0, `wr_ready`=1.
- Read latency: `rd_req` in cycle n gives `rd_valid` and data in cycle n+1. Back-to-back reads give one result per cycle.
- Write latency: a push in cycle n can reach the RAM no earlier than cycle n+1. The FIFO is registered, so there is no bypass.
- `wr_ready`, `level` and `drop_cnt` are registered; `ram_*` outputs are combinational from grant and FIFO head.
- A write stalls indefinitely while `rd_req` stays high. Sustained camera writes therefore need DEPTH ≥ writes per active line segment; overflow is reported, not prevented.

## Structure
- Package `fb_pkg`:
  - `gnt_t` enum {G_NONE, G_RD, G_WR}.
  - `fb_wr_t` struct {addr, data}.
  - Default AW/DW/DEPTH constants shared with the VGA controller and the camera controller.
- Sub-module `fb_wr_fifo`: synchronous FIFO of `fb_wr_t` with push, pop, head, level and full/empty outputs. The arbiter keeps the grant, `gnt_q` and the drop counter.

## Test plan
- Reset then idle: all outputs at reset values; `wr_ready`=1, `level`=0.
- Write then read back:
  - Write addr 0x0012 data 0xA5C3 with `rd_req`=0 → `ram_wren`=1, `ram_addr`=0x0012 one cycle later.
  - Then `rd_req` addr 0x0012 → next cycle `rd_valid`=1, `rd_data`=0xA5C3.
- Read priority: `rd_req` held high for 20 cycles while pushing 3 writes → `ram_wren`=0 throughout, `level`=3. After `rd_req` drops, 3 consecutive write cycles, then `level`=0.
- Overflow with DEPTH=8: `rd_req` high, 10 writes → `wr_ready`=0 after the 8th, `drop_cnt`=2. Then `drop_clr` → `drop_cnt`=0.
- `capture_en`=0 with 4 queued entries and new `wr_req` → queued entries still written, no new push, `drop_cnt` unchanged.
- Reset asserted with `level`=5 and a read in flight → `level`=0 and `rd_valid`=0 immediately; first cycle after reset release `ram_wren`=0.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared frame-buffer types and default geometry for the arbiter, the VGA
// controller and the camera controller.
package fb_pkg;

  localparam int unsigned FB_AW    = 15;
  localparam int unsigned FB_DW    = 16;
  localparam int unsigned FB_DEPTH = 8;

  typedef enum logic [1:0] {
    G_NONE = 2'd0,
    G_RD   = 2'd1,
    G_WR   = 2'd2
  } gnt_t;

  typedef struct packed {
    logic [FB_AW-1:0] addr;
    logic [FB_DW-1:0] data;
  } fb_wr_t;

endpackage

// File: rtl/fb_wr_fifo.sv
// Synchronous write-queue FIFO holding camera {addr,data} entries until the
// frame RAM port is free.
module fb_wr_fifo
  import fb_pkg::*;
#(
  parameter int unsigned AW    = FB_AW,
  parameter int unsigned DW    = FB_DW,
  parameter int unsigned DEPTH = FB_DEPTH,
  localparam int unsigned PW   = $clog2(DEPTH),
  localparam int unsigned LW   = $clog2(DEPTH) + 1
) (
  input  logic          vgaclk,
  input  logic          reset_b,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] push_addr,
  input  logic [DW-1:0] push_data,
  output logic [AW-1:0] head_addr,
  output logic [DW-1:0] head_data,
  output logic [LW-1:0] level,
  output logic          full,
  output logic          empty
);

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } entry_t;

  entry_t        mem [DEPTH];
  entry_t        head;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  assign head      = mem[rd_ptr];
  assign head_addr = empty ? '0 : head.addr;
  assign head_data = empty ? '0 : head.data;

  always_ff @(posedge vgaclk) begin
    if (push_ok) begin
      mem[wr_ptr] <= '{addr: push_addr, data: push_data};
    end
  end

  always_ff @(posedge vgaclk or negedge reset_b) begin
    if (!reset_b) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
      unique case ({push_ok, pop_ok})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/frame_buffer_arbiter.sv
// Single-port frame RAM arbiter: VGA reads always win, queued camera writes
// drain into the RAM on every cycle the VGA side leaves idle.
module frame_buffer_arbiter
  import fb_pkg::*;
#(
  parameter int unsigned AW    = FB_AW,
  parameter int unsigned DW    = FB_DW,
  parameter int unsigned DEPTH = FB_DEPTH
) (
  input  logic                     vgaclk,
  input  logic                     reset_b,
  input  logic                     capture_en,
  input  logic                     wr_req,
  input  logic [AW-1:0]            wr_addr,
  input  logic [DW-1:0]            wr_data,
  output logic                     wr_ready,
  input  logic                     rd_req,
  input  logic [AW-1:0]            rd_addr,
  output logic                     rd_valid,
  output logic [DW-1:0]            rd_data,
  output logic [AW-1:0]            ram_addr,
  output logic [DW-1:0]            ram_data,
  output logic                     ram_wren,
  input  logic [DW-1:0]            ram_q,
  output logic [$clog2(DEPTH):0]   level,
  output logic [7:0]               drop_cnt,
  input  logic                     drop_clr
);

  gnt_t          gnt;
  gnt_t          gnt_q;
  logic          full;
  logic          empty;
  logic          push;
  logic          drop;
  logic [AW-1:0] head_addr;
  logic [DW-1:0] head_data;

  assign push = wr_req & capture_en & ~full;
  assign drop = wr_req & capture_en & full;

  fb_wr_fifo #(
    .AW    (AW),
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .vgaclk    (vgaclk),
    .reset_b   (reset_b),
    .push      (push),
    .pop       (gnt == G_WR),
    .push_addr (wr_addr),
    .push_data (wr_data),
    .head_addr (head_addr),
    .head_data (head_data),
    .level     (level),
    .full      (full),
    .empty     (empty)
  );

  assign wr_ready = ~full;

  always_comb begin
    gnt = G_NONE;
    if (rd_req)      gnt = G_RD;
    else if (!empty) gnt = G_WR;
  end

  always_comb begin
    ram_addr = '0;
    unique case (gnt)
      G_RD:    ram_addr = rd_addr;
      G_WR:    ram_addr = head_addr;
      default: ram_addr = '0;
    endcase
  end

  assign ram_wren = (gnt == G_WR);
  assign ram_data = head_data;

  assign rd_valid = (gnt_q == G_RD);
  assign rd_data  = rd_valid ? ram_q : '0;

  always_ff @(posedge vgaclk or negedge reset_b) begin
    if (!reset_b) begin
      gnt_q <= G_NONE;
    end else begin
      gnt_q <= gnt;
    end
  end

  // Clear wins over a same-cycle drop so software always observes zero.
  always_ff @(posedge vgaclk or negedge reset_b) begin
    if (!reset_b) begin
      drop_cnt <= '0;
    end else if (drop_clr) begin
      drop_cnt <= '0;
    end else if (drop && (drop_cnt != '1)) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_frame_buffer_arbiter.sv
// Directed bench for frame_buffer_arbiter with a behavioural single-port RAM.
module tb_frame_buffer_arbiter;

  localparam int unsigned AW    = 15;
  localparam int unsigned DW    = 16;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned LW    = 4;

  logic          vgaclk = 1'b0;
  logic          reset_b = 1'b0;
  logic          capture_en = 1'b1;
  logic          wr_req = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_ready;
  logic          rd_req = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data;
  logic          ram_wren;
  logic [DW-1:0] ram_q = '0;
  logic [LW-1:0] level;
  logic [7:0]    drop_cnt;
  logic          drop_clr = 1'b0;

  logic [DW-1:0] mem [2**AW];

  int checks   = 0;
  int failures = 0;

  frame_buffer_arbiter #(
    .AW    (AW),
    .DW    (DW),
    .DEPTH (DEPTH)
  ) dut (
    .vgaclk     (vgaclk),
    .reset_b    (reset_b),
    .capture_en (capture_en),
    .wr_req     (wr_req),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .rd_req     (rd_req),
    .rd_addr    (rd_addr),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .ram_addr   (ram_addr),
    .ram_data   (ram_data),
    .ram_wren   (ram_wren),
    .ram_q      (ram_q),
    .level      (level),
    .drop_cnt   (drop_cnt),
    .drop_clr   (drop_clr)
  );

  always #5 vgaclk = ~vgaclk;

  always @(posedge vgaclk) begin
    if (ram_wren) mem[ram_addr] <= ram_data;
    ram_q <= mem[ram_addr];
  end

  typedef struct {
    logic          rd;
    logic [AW-1:0] raddr;
    logic          wr;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic          e_wren;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;
    logic          e_rv;
    logic [DW-1:0] e_rd;
    logic [LW-1:0] e_lvl;
    logic          e_rdy;
  } vec_t;

  vec_t vt [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit later.
  task automatic drive(input logic rd, input logic [AW-1:0] ra, input logic wr,
                       input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic cap, input logic clr);
    @(negedge vgaclk);
    rd_req = rd; rd_addr = ra; wr_req = wr; wr_addr = wa; wr_data = wd;
    capture_en = cap; drop_clr = clr;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, '0, 1'b0, '0, '0, 1'b1, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge vgaclk);
    reset_b = 1'b0; rd_req = 1'b0; wr_req = 1'b0; drop_clr = 1'b0; capture_en = 1'b1;
    @(posedge vgaclk);
    @(posedge vgaclk);
    @(negedge vgaclk);
    reset_b = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 2**AW; i++) mem[i] = '0;

    //            rd    raddr    wr    waddr    wdata     wren  addr     data      rv    rdata     lvl  rdy
    vt[0]  = '{1'b0, 15'h0,  1'b0, 15'h0,  16'h0,    1'b0, 15'h0,  16'h0,    1'b0, 16'h0,    4'd0, 1'b1};
    vt[1]  = '{1'b0, 15'h0,  1'b1, 15'h12, 16'hA5C3, 1'b0, 15'h0,  16'h0,    1'b0, 16'h0,    4'd0, 1'b1};
    vt[2]  = '{1'b0, 15'h0,  1'b0, 15'h0,  16'h0,    1'b1, 15'h12, 16'hA5C3, 1'b0, 16'h0,    4'd1, 1'b1};
    vt[3]  = '{1'b1, 15'h12, 1'b0, 15'h0,  16'h0,    1'b0, 15'h12, 16'h0,    1'b0, 16'h0,    4'd0, 1'b1};
    vt[4]  = '{1'b0, 15'h0,  1'b0, 15'h0,  16'h0,    1'b0, 15'h0,  16'h0,    1'b1, 16'hA5C3, 4'd0, 1'b1};
    vt[5]  = '{1'b0, 15'h0,  1'b0, 15'h0,  16'h0,    1'b0, 15'h0,  16'h0,    1'b0, 16'h0,    4'd0, 1'b1};
    vt[6]  = '{1'b1, 15'h20, 1'b1, 15'h20, 16'h1111, 1'b0, 15'h20, 16'h0,    1'b0, 16'h0,    4'd0, 1'b1};
    vt[7]  = '{1'b1, 15'h12, 1'b0, 15'h0,  16'h0,    1'b0, 15'h12, 16'h1111, 1'b1, 16'h0,    4'd1, 1'b1};
    vt[8]  = '{1'b0, 15'h0,  1'b0, 15'h0,  16'h0,    1'b1, 15'h20, 16'h1111, 1'b1, 16'hA5C3, 4'd1, 1'b1};
    vt[9]  = '{1'b1, 15'h20, 1'b0, 15'h0,  16'h0,    1'b0, 15'h20, 16'h0,    1'b0, 16'h0,    4'd0, 1'b1};
    vt[10] = '{1'b0, 15'h0,  1'b0, 15'h0,  16'h0,    1'b0, 15'h0,  16'h0,    1'b1, 16'h1111, 4'd0, 1'b1};

    do_reset();
    #1;
    chk("rst_wren",     32'(ram_wren), 32'd0);
    chk("rst_addr",     32'(ram_addr), 32'd0);
    chk("rst_data",     32'(ram_data), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_rd_data",  32'(rd_data),  32'd0);
    chk("rst_level",    32'(level),    32'd0);
    chk("rst_wr_ready", 32'(wr_ready), 32'd1);
    chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);

    // Write/readback, stale read of a queued address, back-to-back reads.
    for (int i = 0; i < 11; i++) begin
      drive(vt[i].rd, vt[i].raddr, vt[i].wr, vt[i].waddr, vt[i].wdata, 1'b1, 1'b0);
      chk($sformatf("v%0d_wren", i),     32'(ram_wren), 32'(vt[i].e_wren));
      chk($sformatf("v%0d_addr", i),     32'(ram_addr), 32'(vt[i].e_addr));
      chk($sformatf("v%0d_data", i),     32'(ram_data), 32'(vt[i].e_data));
      chk($sformatf("v%0d_rd_valid", i), 32'(rd_valid), 32'(vt[i].e_rv));
      chk($sformatf("v%0d_rd_data", i),  32'(rd_data),  32'(vt[i].e_rd));
      chk($sformatf("v%0d_level", i),    32'(level),    32'(vt[i].e_lvl));
      chk($sformatf("v%0d_wr_ready", i), 32'(wr_ready), 32'(vt[i].e_rdy));
    end

    // Read priority: 20 read cycles with 3 pushes, then in-order drain.
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 15'h40, (i < 3), 15'(32'h100 + i), 16'(32'hB000 + i), 1'b1, 1'b0);
      chk($sformatf("prio_wren_%0d", i), 32'(ram_wren), 32'd0);
    end
    for (int j = 0; j < 4; j++) begin
      idle();
      if (j == 0) chk("prio_level_before", 32'(level), 32'd3);
      chk($sformatf("drain_wren_%0d", j), 32'(ram_wren), (j < 3) ? 32'd1 : 32'd0);
      if (j < 3) begin
        chk($sformatf("drain_addr_%0d", j), 32'(ram_addr), 32'h100 + 32'(j));
        chk($sformatf("drain_data_%0d", j), 32'(ram_data), 32'hB000 + 32'(j));
      end
    end
    chk("drain_level_after", 32'(level), 32'd0);

    // Overflow: 10 writes into an 8-deep FIFO while reads hold the port.
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 15'h40, 1'b1, 15'(32'h180 + i), 16'(i), 1'b1, 1'b0);
      chk($sformatf("ovf_ready_%0d", i), 32'(wr_ready), (i < 8) ? 32'd1 : 32'd0);
    end
    drive(1'b1, 15'h40, 1'b0, '0, '0, 1'b1, 1'b0);
    chk("ovf_drop_cnt", 32'(drop_cnt), 32'd2);
    chk("ovf_level",    32'(level),    32'd8);
    drive(1'b1, 15'h40, 1'b0, '0, '0, 1'b1, 1'b1);
    drive(1'b1, 15'h40, 1'b0, '0, '0, 1'b1, 1'b0);
    chk("clr_drop_cnt", 32'(drop_cnt), 32'd0);
    drive(1'b1, 15'h40, 1'b1, 15'h1FF, 16'h0, 1'b1, 1'b1);
    drive(1'b1, 15'h40, 1'b0, '0, '0, 1'b1, 1'b0);
    chk("clr_and_drop", 32'(drop_cnt), 32'd0);
    for (int i = 0; i < 300; i++) drive(1'b1, 15'h40, 1'b1, 15'h1FF, 16'h0, 1'b1, 1'b0);
    drive(1'b1, 15'h40, 1'b0, '0, '0, 1'b1, 1'b0);
    chk("drop_saturate", 32'(drop_cnt), 32'd255);
    chk("ovf_level_still_full", 32'(level), 32'd8);

    // capture_en=0: queued writes drain, new requests are neither pushed nor counted.
    do_reset();
    for (int i = 0; i < 4; i++) drive(1'b1, 15'h40, 1'b1, 15'(32'h200 + i), 16'(32'hC000 + i), 1'b1, 1'b0);
    for (int j = 0; j < 6; j++) begin
      drive(1'b0, '0, 1'b1, 15'h7FFF, 16'hDEAD, 1'b0, 1'b0);
      chk($sformatf("cap_wren_%0d", j), 32'(ram_wren), (j < 4) ? 32'd1 : 32'd0);
      if (j < 4) chk($sformatf("cap_addr_%0d", j), 32'(ram_addr), 32'h200 + 32'(j));
    end
    idle();
    chk("cap_level",    32'(level),    32'd0);
    chk("cap_drop_cnt", 32'(drop_cnt), 32'd0);
    chk("cap_mem",      32'(mem[15'h203]), 32'hC003);

    // Asynchronous reset with a full-ish FIFO and a read in flight.
    do_reset();
    for (int i = 0; i < 5; i++) drive(1'b1, 15'h40, 1'b1, 15'(32'h300 + i), 16'(i), 1'b1, 1'b0);
    drive(1'b1, 15'h12, 1'b0, '0, '0, 1'b1, 1'b0);
    chk("pre_rst_level", 32'(level), 32'd5);
    @(negedge vgaclk);
    rd_req = 1'b0;
    chk("pre_rst_rd_valid", 32'(rd_valid), 32'd1);
    reset_b = 1'b0;
    #1;
    chk("mid_rst_level",    32'(level),    32'd0);
    chk("mid_rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("mid_rst_rd_data",  32'(rd_data),  32'd0);
    chk("mid_rst_wr_ready", 32'(wr_ready), 32'd1);
    @(posedge vgaclk);
    @(negedge vgaclk);
    reset_b = 1'b1;
    #1;
    chk("post_rst_wren",  32'(ram_wren), 32'd0);
    chk("post_rst_addr",  32'(ram_addr), 32'd0);
    idle();
    chk("post_rst_wren2", 32'(ram_wren), 32'd0);
    chk("post_rst_level", 32'(level),    32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
